// File: rtl/axi_lite_mtimer.sv
// axi_lite_mtimer
//   AXI4-Lite responder implementing a RISC-V machine timer: 64-bit mtime
//   and mtimecmp, a prescaler, and a registered level timer interrupt.
//
// Ports
//   s_axi_aclk, s_axi_aresetn      clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*                write address / data / response channels
//   s_axi_ar*/r*                   read address / data channels
//   irq_o                          timer interrupt, IRQ_EN & (mtime >= mtimecmp)
//
// Register map (byte offset, addr[1:0] ignored)
//   0x00 MTIME_LO  0x04 MTIME_HI  0x08 CMP_LO  0x0C CMP_HI
//   0x10 CTRL (bit0 EN, bit1 IRQ_EN)  0x14 PRESCALE; anything else -> SLVERR
module axi_lite_mtimer #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter logic [31:0] PRESCALE_RESET = 32'd0,
  parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  irq_o
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Timer state
  logic [63:0] r_mtime, r_cmp;
  logic [1:0]  r_ctrl;
  logic [31:0] r_prescale, r_pcnt;
  logic        r_irq;
  // Holds every ready low while in reset and for the first cycle after it
  logic        r_live;

  // Write channel
  wstate_t                r_wstate, w_wstate_next;
  logic                   r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]  r_awaddr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic [1:0]             r_bresp;

  // Read channel
  rstate_t     r_rstate, w_rstate_next;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
  logic [31:0] w_widx, w_ridx, w_bmask, w_rdata_mux;
  logic [1:0]  w_rresp_mux;
  logic        w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_pre, w_wmapped;
  logic        w_tick;
  logic [63:0] w_mtime_inc;
  logic        w_unused;

  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- handshakes / outputs ----------------
  assign s_axi_awready = r_live & ~r_aw_held & (r_wstate == W_IDLE);
  assign s_axi_wready  = r_live & ~r_w_held  & (r_wstate == W_IDLE);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_live & (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign irq_o         = r_irq;

  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;

  // The register update happens the cycle after both halves are latched
  assign w_wr_fire = (r_wstate == W_IDLE) & r_aw_held & r_w_held;

  // ---------------- write decode ----------------
  assign w_widx    = 32'(r_awaddr[ADDR_WIDTH-1:2]);
  assign w_wmapped = (w_widx < 32'd6);
  assign w_wr_mlo  = w_wr_fire & (w_widx == 32'd0);
  assign w_wr_mhi  = w_wr_fire & (w_widx == 32'd1);
  assign w_wr_clo  = w_wr_fire & (w_widx == 32'd2);
  assign w_wr_chi  = w_wr_fire & (w_widx == 32'd3);
  assign w_wr_ctrl = w_wr_fire & (w_widx == 32'd4);
  assign w_wr_pre  = w_wr_fire & (w_widx == 32'd5);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bmask
    assign w_bmask[8*gi +: 8] = {8{r_wstrb[gi]}};
  end

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // ---------------- counter ----------------
  assign w_tick      = r_ctrl[0] & (r_pcnt == r_prescale);
  assign w_mtime_inc = r_mtime + 64'(w_tick);

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_fire) w_wstate_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_live    <= 1'b0;
    end else begin
      r_wstate <= w_wstate_next;
      r_live   <= 1'b1;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_wr_fire) r_bresp <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
      if ((r_wstate == W_RESP) && s_axi_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // ---------------- timer registers ----------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_mtime    <= '0;
      r_cmp      <= CMP_RESET;
      r_ctrl     <= '0;
      r_prescale <= PRESCALE_RESET;
      r_pcnt     <= '0;
      r_irq      <= 1'b0;
    end else begin
      // A software write to mtime suppresses that cycle's increment: written
      // bytes take wdata, all other bytes keep the pre-increment value.
      if (w_wr_mlo || w_wr_mhi) begin
        r_mtime <= {w_wr_mhi ? f_merge(r_mtime[63:32], r_wdata, w_bmask) : r_mtime[63:32],
                    w_wr_mlo ? f_merge(r_mtime[31:0],  r_wdata, w_bmask) : r_mtime[31:0]};
      end else begin
        r_mtime <= w_mtime_inc;
      end
      if (w_wr_clo) r_cmp[31:0]  <= f_merge(r_cmp[31:0],  r_wdata, w_bmask);
      if (w_wr_chi) r_cmp[63:32] <= f_merge(r_cmp[63:32], r_wdata, w_bmask);
      if (w_wr_ctrl && r_wstrb[0]) r_ctrl <= r_wdata[1:0];
      if (w_wr_pre) r_prescale <= f_merge(r_prescale, r_wdata, w_bmask);

      if (w_wr_pre)       r_pcnt <= '0;
      else if (w_tick)    r_pcnt <= '0;
      else if (r_ctrl[0]) r_pcnt <= r_pcnt + 32'd1;

      r_irq <= r_ctrl[1] & (r_mtime >= r_cmp);
    end
  end

  // ---------------- read path ----------------
  assign w_ridx = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    w_rdata_mux = 32'd0;
    w_rresp_mux = RESP_OKAY;
    case (w_ridx)
      32'd0:   w_rdata_mux = r_mtime[31:0];
      32'd1:   w_rdata_mux = r_mtime[63:32];
      32'd2:   w_rdata_mux = r_cmp[31:0];
      32'd3:   w_rdata_mux = r_cmp[63:32];
      32'd4:   w_rdata_mux = {30'd0, r_ctrl};
      32'd5:   w_rdata_mux = r_prescale;
      default: w_rresp_mux = RESP_SLVERR;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_next;
      // Captured from current register values, so a same-cycle write is not seen
      if (w_ar_hs) begin
        r_rdata <= w_rdata_mux;
        r_rresp <= w_rresp_mux;
      end
    end
  end

endmodule
